// File: rtl/shift_pkg.sv
// Shared definitions for the fixed-point shifter pair: the FSM state encoding
// and the default data and shift-amount widths.
package shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DATA_W  = 16;
    localparam int SHAMT_W = 4;

endpackage

// File: rtl/rshift_stage.sv
// One log-shifter stage: optionally shifts right by 2**STAGE and fills the
// vacated high bits with the supplied fill bit.
module rshift_stage #(
    parameter int WIDTH = 16,
    parameter int STAGE = 0
) (
    input  logic [WIDTH-1:0] value,
    input  logic             en,
    input  logic             fill,
    output logic [WIDTH-1:0] shifted
);

    localparam int DIST = 1 << STAGE;
    localparam logic [WIDTH-1:0] FILL_MASK = ~({WIDTH{1'b1}} >> DIST);

    always_comb begin
        shifted = value;
        if (en) begin
            shifted = (value >> DIST) | (fill ? FILL_MASK : '0);
        end
    end

endmodule

// File: rtl/bit_shift_right16_seq.sv
// Multi-cycle right shifter with logical/arithmetic modes, applying one
// log-shifter stage per cycle behind valid/ready handshakes.
//
//   state | meaning
//   IDLE  | in_ready high, waiting for a request
//   SHIFT | applying stage k to the working value, one stage per cycle
//   DONE  | out_valid high, holding the result until out_ready
module bit_shift_right16_seq
    import shift_pkg::*;
#(
    parameter int WIDTH  = DATA_W,
    parameter int STAGES = SHAMT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out
);

    localparam int K_W = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(STAGES - 1);

    state_t              state_q, state_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [WIDTH-1:0]    work_q, work_d;
    logic [STAGES-1:0]   shamt_q, shamt_d;
    logic                arith_q, arith_d;
    logic                sign_q, sign_d;
    logic [WIDTH-1:0]    out_q, out_d;

    logic [WIDTH-1:0]    stage_out [STAGES];
    logic [WIDTH-1:0]    stage_sel;
    logic                fill;
    logic                out_of_range;
    logic                accept;

    // Fill comes from the original operand sign, not the working value.
    assign fill = arith_q & sign_q;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        rshift_stage #(
            .WIDTH (WIDTH),
            .STAGE (i)
        ) u_stage (
            .value   (work_q),
            .en      (shamt_q[i]),
            .fill    (fill),
            .shifted (stage_out[i])
        );
    end

    assign stage_sel    = stage_out[k_q];
    assign out_of_range = |b[WIDTH-1:STAGES];
    assign accept       = in_valid && (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        work_d  = work_q;
        shamt_d = shamt_q;
        arith_d = arith_q;
        sign_d  = sign_q;
        out_d   = out_q;

        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    work_d  = a;
                    shamt_d = b[STAGES-1:0];
                    arith_d = arith;
                    sign_d  = a[WIDTH-1];
                    k_d     = '0;
                    if (out_of_range) begin
                        out_d   = (arith && a[WIDTH-1]) ? {WIDTH{1'b1}} : '0;
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                work_d = stage_sel;
                if (k_q == K_LAST) begin
                    out_d   = stage_sel;
                    k_d     = '0;
                    state_d = DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            work_q  <= '0;
            shamt_q <= '0;
            arith_q <= 1'b0;
            sign_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            work_q  <= work_d;
            shamt_q <= shamt_d;
            arith_q <= arith_d;
            sign_q  <= sign_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;

endmodule

// File: tb/tb_bit_shift_right16_seq.sv
// Directed bench for the multi-cycle right shifter: a vector table for the
// shift function and latency, plus backpressure and mid-shift reset sequences.
module tb_bit_shift_right16_seq;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         arith;
        logic [W-1:0] exp_out;
        int           exp_lat;
    } vec_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         arith;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;

    int errors = 0;
    int checks = 0;

    bit_shift_right16_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .arith     (arith),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called right after the accepting edge; scrambles the now don't-care inputs.
    task automatic wait_result(input string name, input logic [W-1:0] exp_out, input int exp_lat);
        int n;
        bit seen;
        #1;
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
        arith    = 1'($urandom);
        n        = 0;
        seen     = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else n++;
        end
        if (!seen) begin
            errors++;
            checks++;
            $display("FAIL %s timeout: out_valid never rose, expected latency %0d", name, exp_lat);
        end else begin
            check({name, " latency"}, 32'(n), 32'(exp_lat));
            check({name, " out"}, 32'(out), 32'(exp_out));
            check({name, " in_ready in DONE"}, 32'(in_ready), 32'd0);
        end
    endtask

    task automatic release_result(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check({name, " in_ready after handshake"}, 32'(in_ready), 32'd1);
        check({name, " out_valid after handshake"}, 32'(out_valid), 32'd0);
    endtask

    task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic varith);
        @(negedge clk);
        a        = va;
        b        = vb;
        arith    = varith;
        in_valid = 1'b1;
        @(posedge clk);
    endtask

    vec_t vecs [14];

    initial begin
        vecs[0]  = '{16'h0001, 16'h0000, 1'b0, 16'h0001, 4};
        vecs[1]  = '{16'h8000, 16'h000F, 1'b0, 16'h0001, 4};
        vecs[2]  = '{16'h8000, 16'h000F, 1'b1, 16'hFFFF, 4};
        vecs[3]  = '{16'h8000, 16'h0001, 1'b1, 16'hC000, 4};
        vecs[4]  = '{16'h8000, 16'h0001, 1'b0, 16'h4000, 4};
        vecs[5]  = '{16'h8234, 16'h0010, 1'b1, 16'hFFFF, 0};
        vecs[6]  = '{16'h8234, 16'h0010, 1'b0, 16'h0000, 0};
        vecs[7]  = '{16'h8234, 16'hFFFF, 1'b1, 16'hFFFF, 0};
        vecs[8]  = '{16'h8234, 16'hFFFF, 1'b0, 16'h0000, 0};
        vecs[9]  = '{16'hF0F0, 16'h0003, 1'b1, 16'hFE1E, 4};
        vecs[10] = '{16'hF0F0, 16'h0003, 1'b0, 16'h1E1E, 4};
        vecs[11] = '{16'hABCD, 16'h0008, 1'b1, 16'hFFAB, 4};
        vecs[12] = '{16'h7FFF, 16'h000F, 1'b1, 16'h0000, 4};
        vecs[13] = '{16'h1234, 16'h0004, 1'b0, 16'h0123, 4};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        arith     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset out", 32'(out), 32'd0);

        for (int i = 0; i < 14; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            check({nm, " in_ready idle"}, 32'(in_ready), 32'd1);
            issue(vecs[i].a, vecs[i].b, vecs[i].arith);
            wait_result(nm, vecs[i].exp_out, vecs[i].exp_lat);
            release_result(nm);
        end

        // Backpressure: result held while a competing request is presented.
        issue(16'h00F0, 16'h0004, 1'b0);
        wait_result("bp", 16'h000F, 4);
        for (int c = 0; c < 3; c++) begin
            a        = 16'h1111;
            b        = 16'h0001;
            arith    = 1'b0;
            in_valid = (c != 1);
            @(negedge clk);
            check("bp out stable", 32'(out), 32'h000F);
            check("bp out_valid held", 32'(out_valid), 32'd1);
            check("bp in_ready low", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("bp in_ready after handshake", 32'(in_ready), 32'd1);
        check("bp out_valid after handshake", 32'(out_valid), 32'd0);
        @(posedge clk);
        wait_result("bp second", 16'h0888, 4);
        release_result("bp second");

        // Reset while in SHIFT with k = 2; previous result left out nonzero.
        issue(16'h8000, 16'h000F, 1'b1);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst in_ready", 32'(in_ready), 32'd1);
        check("midrst out", 32'(out), 32'd0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("midrst no valid pulse", 32'(out_valid), 32'd0);
        end
        issue(16'hABCD, 16'h0008, 1'b0);
        wait_result("post rst", 16'h00AB, 4);
        release_result("post rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
